// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel position from VGA syncs, checks timing, tracks lock and checksums each frame
module vga_sync_decoder #(
    parameter int   HOR_FIELD    = 1279,
    parameter int   HOR_STR_SYNC = 1327,
    parameter int   HOR_STP_SYNC = 1439,
    parameter int   HOR_TOTAL    = 1687,
    parameter int   VER_FIELD    = 1023,
    parameter int   VER_STR_SYNC = 1024,
    parameter int   VER_STP_SYNC = 1027,
    parameter int   VER_TOTAL    = 1065,
    parameter logic HS_POL       = 1'b1,
    parameter logic VS_POL       = 1'b1,
    parameter int   LOCK_LINES   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [3:0]  red,
    input  logic [3:0]  green,
    input  logic [3:0]  blue,
    output logic [11:0] col,
    output logic [10:0] row,
    output logic        pix_valid,
    output logic        locked,
    output logic        lock_lost,
    output logic [7:0]  err_count,
    output logic [23:0] frame_sum,
    output logic        frame_done
);
    localparam logic [11:0] H_FLD = 12'(HOR_FIELD);
    localparam logic [11:0] H_SS  = 12'(HOR_STR_SYNC);
    localparam logic [11:0] H_SP1 = 12'(HOR_STP_SYNC + 1);
    localparam logic [11:0] H_TOT = 12'(HOR_TOTAL);
    localparam logic [10:0] V_FLD = 11'(VER_FIELD);
    localparam logic [10:0] V_SS  = 11'(VER_STR_SYNC);
    localparam logic [10:0] V_SP1 = 11'(VER_STP_SYNC + 1);
    localparam logic [10:0] V_TOT = 11'(VER_TOTAL);
    localparam logic [7:0]  LOCK_N = 8'(LOCK_LINES);

    typedef enum logic [2:0] {SEARCH, H_TRACK, V_WAIT, V_TRACK, LOCKED} state_t;

    state_t      state, state_n;
    logic        hs_prev, vs_prev;
    logic        hs_on, vs_on, hs_rise, hs_fall, vs_rise, vs_fall;
    logic [11:0] pc, pc_p, pc_n;
    logic [10:0] pr, pr_p, pr_n;
    logic [7:0]  good, good_n;
    logic [23:0] acc, sum_n;
    logic        line_err, frame_err, err, vis, last;

    assign hs_on   = hsync == HS_POL;
    assign vs_on   = vsync == VS_POL;
    assign hs_rise = hs_on && !hs_prev;
    assign hs_fall = !hs_on && hs_prev;
    assign vs_rise = vs_on && !vs_prev;
    assign vs_fall = !vs_on && vs_prev;

    // Predicted position for this sample, re-anchored by sync assertion edges
    always_comb begin
        pc_p = (pc == H_TOT) ? '0 : pc + 12'd1;
        pr_p = (pc != H_TOT) ? pr : (pr == V_TOT) ? '0 : pr + 11'd1;
        pc_n = hs_rise ? H_SS : pc_p;
        pr_n = vs_rise ? V_SS : pr_p;
    end

    // Timing violations judged against the prediction before re-anchoring
    always_comb begin
        line_err  = (hs_rise && pc_p != H_SS) || (!hs_rise && pc_p == H_SS) ||
                    (hs_fall && pc_p != H_SP1) || (hs_on && pc_p == H_SP1);
        frame_err = (vs_rise && (pr_p != V_SS || pc_p != '0)) ||
                    (!vs_rise && pr_p == V_SS && pc_p == '0) ||
                    (vs_fall && (pr_p != V_SP1 || pc_p != '0));
        err       = (state != SEARCH) &&
                    (line_err || (frame_err && (state == V_TRACK || state == LOCKED)));
    end

    // Lock acquisition: horizontal first, then two consecutive frame edges; any error restarts
    always_comb begin
        state_n = state;
        good_n  = good;
        case (state)
            SEARCH: begin
                if (hs_rise) begin
                    state_n = H_TRACK;
                    good_n  = '0;
                end
            end
            H_TRACK: begin
                if (err) begin
                    state_n = SEARCH;
                end else if (hs_rise) begin
                    good_n  = good + 8'd1;
                    state_n = (good + 8'd1 == LOCK_N) ? V_WAIT : H_TRACK;
                end
            end
            V_WAIT:  state_n = err ? SEARCH : (vs_rise && pc_p == '0) ? V_TRACK : V_WAIT;
            V_TRACK: state_n = err ? SEARCH : vs_rise ? LOCKED : V_TRACK;
            LOCKED:  state_n = err ? SEARCH : LOCKED;
            default: state_n = SEARCH;
        endcase
    end

    // Checksum terms for the current sample
    always_comb begin
        vis   = state_n == LOCKED && pc_n <= H_FLD && pr_n <= V_FLD;
        last  = vis && pc_n == H_FLD && pr_n == V_FLD;
        sum_n = ((pc_n == '0 && pr_n == '0) ? 24'd0 : acc) + {12'd0, red, green, blue};
    end

    // Sync history, predicted position and lock state
    always_ff @(posedge clock) begin
        if (!reset) begin
            hs_prev <= 1'b0;
            vs_prev <= 1'b0;
            pc      <= '0;
            pr      <= '0;
            good    <= '0;
            state   <= SEARCH;
        end else begin
            hs_prev <= hs_on;
            vs_prev <= vs_on;
            pc      <= pc_n;
            pr      <= pr_n;
            good    <= good_n;
            state   <= state_n;
        end
    end

    // Registered position, validity and lock status describing the sample just taken
    always_ff @(posedge clock) begin
        if (!reset) begin
            col       <= '0;
            row       <= '0;
            pix_valid <= 1'b0;
            locked    <= 1'b0;
            lock_lost <= 1'b0;
            err_count <= '0;
        end else begin
            col       <= (state_n == SEARCH) ? '0 : pc_n;
            row       <= (state_n == V_TRACK || state_n == LOCKED) ? pr_n : '0;
            pix_valid <= vis;
            locked    <= state_n == LOCKED;
            lock_lost <= state == LOCKED && err;
            err_count <= (state == LOCKED && err && err_count != 8'hff) ? err_count + 8'd1 : err_count;
        end
    end

    // Frame checksum: restart at the first visible pixel, publish at the last one
    always_ff @(posedge clock) begin
        if (!reset) begin
            acc        <= '0;
            frame_sum  <= '0;
            frame_done <= 1'b0;
        end else begin
            acc        <= vis ? sum_n : acc;
            frame_sum  <= last ? sum_n : frame_sum;
            frame_done <= last;
        end
    end
endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: drives a small-timing VGA stream and scoreboards the recovered position and checksum
module tb_vga_sync_decoder;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        hsync = 1'b0;
    logic        vsync = 1'b0;
    logic [3:0]  red = '0, green = '0, blue = '0;
    logic [11:0] col;
    logic [10:0] row;
    logic        pix_valid, locked, lock_lost, frame_done;
    logic [7:0]  err_count;
    logic [23:0] frame_sum;

    typedef struct {
        logic [11:0] col;
        logic [10:0] row;
        logic        pv;
        logic        fd;
        logic [23:0] fs;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          gc = 0, gr = 0, lc = 0, lr = 0;
    int          hmode = 0;
    int          pv_cnt = 0, fd_cnt = 0;
    logic        vs_en = 1'b1;
    logic        track = 1'b0;
    logic        rgb_mode = 1'b0;
    logic [23:0] run_sum = '0;

    vga_sync_decoder #(
        .HOR_FIELD(9), .HOR_STR_SYNC(11), .HOR_STP_SYNC(13), .HOR_TOTAL(15),
        .VER_FIELD(5), .VER_STR_SYNC(6), .VER_STP_SYNC(7), .VER_TOTAL(9),
        .HS_POL(1'b1), .VS_POL(1'b1), .LOCK_LINES(4)
    ) dut (
        .clock(clock), .reset(reset), .hsync(hsync), .vsync(vsync),
        .red(red), .green(green), .blue(blue),
        .col(col), .row(row), .pix_valid(pix_valid), .locked(locked),
        .lock_lost(lock_lost), .err_count(err_count), .frame_sum(frame_sum),
        .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    function automatic logic hs_level(int c, int m);
        return (m == 2) ? 1'b0 : (m == 1) ? (c >= 12 && c <= 14) : (c >= 11 && c <= 13);
    endfunction

    task automatic tick();
        exp_t        e;
        logic [11:0] pix;
        pix   = rgb_mode ? 12'(gc) : 12'h001;
        hsync = hs_level(gc, hmode);
        vsync = vs_en && gr >= 6 && gr <= 7;
        {red, green, blue} = pix;
        if (gc <= 9 && gr <= 5) run_sum = (gc == 0 && gr == 0) ? 24'(pix) : run_sum + 24'(pix);
        if (track) begin
            e.col = 12'(gc);
            e.row = 11'(gr);
            e.pv  = gc <= 9 && gr <= 5;
            e.fd  = gc == 9 && gr == 5;
            e.fs  = run_sum;
            sb.push_back(e);
        end
        @(posedge clock);
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            tests++;
            if ({locked, col, row, pix_valid, frame_done} !== {1'b1, e.col, e.row, e.pv, e.fd}) begin
                fails++;
                $display("FAIL sb_pos (%0d,%0d): got lk=%b col=%0d row=%0d pv=%b fd=%b, want lk=1 col=%0d row=%0d pv=%b fd=%b",
                         gc, gr, locked, col, row, pix_valid, frame_done, e.col, e.row, e.pv, e.fd);
            end
            if (e.fd) begin
                tests++;
                if (frame_sum !== e.fs) begin
                    fails++;
                    $display("FAIL sb_sum: got %0d want %0d", frame_sum, e.fs);
                end
            end
        end
        pv_cnt += int'(pix_valid);
        fd_cnt += int'(frame_done);
        lc = gc;
        lr = gr;
        if (gc == 15) begin
            gc = 0;
            hmode = 0;
            gr = (gr == 9) ? 0 : gr + 1;
        end else begin
            gc++;
        end
    endtask

    task automatic run_to(int c, int r);
        int k = 0;
        do begin
            tick();
            k++;
        end while (!(lc == c && lr == r) && k < 400);
        tests++;
        if (!(lc == c && lr == r)) begin
            fails++;
            $display("FAIL run_to: stopped at (%0d,%0d) want (%0d,%0d)", lc, lr, c, r);
        end
    endtask

    task automatic wait_lock(output int n);
        n = 0;
        while (n < 600) begin
            tick();
            if (locked) break;
            n++;
        end
        tests++;
        if (!locked) begin
            fails++;
            $display("FAIL wait_lock: locked=%b after %0d samples", locked, n);
        end
    endtask

    task automatic reset_dut();
        track = 1'b0;
        reset = 1'b0;
        hsync = 1'b0;
        vsync = 1'b0;
        {red, green, blue} = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        gc = 0;
        gr = 0;
        hmode = 0;
    endtask

    task automatic test_reset();
        reset_dut();
        tests++;
        if ({col, row, pix_valid, locked, lock_lost, err_count, frame_sum, frame_done} !== 59'd0) begin
            fails++;
            $display("FAIL reset_state: got col=%0d row=%0d pv=%b lk=%b ll=%b ec=%0d fs=%0d fd=%b want all 0",
                     col, row, pix_valid, locked, lock_lost, err_count, frame_sum, frame_done);
        end
    endtask

    task automatic test_lock();
        int n;
        wait_lock(n);
        tests++;
        if (n != 256) begin
            fails++;
            $display("FAIL lock_time: locked at sample %0d want 256", n);
        end
        track = 1'b1;
        run_to(15, 9);
        pv_cnt = 0;
        fd_cnt = 0;
        repeat (320) tick();
        tests++;
        if (fd_cnt != 2 || pv_cnt != 120) begin
            fails++;
            $display("FAIL frame_counts: got done=%0d valid=%0d want done=2 valid=120", fd_cnt, pv_cnt);
        end
        tests++;
        if (frame_sum !== 24'd60) begin
            fails++;
            $display("FAIL sum_ones: got %0d want 60", frame_sum);
        end
    endtask

    task automatic test_hs_error();
        int n;
        track = 1'b0;
        run_to(15, 7);
        hmode = 1;
        run_to(11, 8);
        tests++;
        if ({lock_lost, locked, err_count} !== {1'b1, 1'b0, 8'd1}) begin
            fails++;
            $display("FAIL hs_late: got ll=%b lk=%b ec=%0d want ll=1 lk=0 ec=1", lock_lost, locked, err_count);
        end
        tick();
        tests++;
        if (lock_lost !== 1'b0) begin
            fails++;
            $display("FAIL lost_pulse: got %b want 0", lock_lost);
        end
        wait_lock(n);
        tests++;
        if (n > 320 || err_count !== 8'd1) begin
            fails++;
            $display("FAIL relock: got %0d samples ec=%0d want <=320 ec=1", n, err_count);
        end
    endtask

    task automatic test_checksum();
        rgb_mode = 1'b1;
        track = 1'b1;
        run_to(9, 5);
        tests++;
        if ({frame_done, frame_sum} !== {1'b1, 24'd270}) begin
            fails++;
            $display("FAIL sum_cols: got fd=%b sum=%0d want fd=1 sum=270", frame_done, frame_sum);
        end
        rgb_mode = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n;
        run_to(4, 2);
        track = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tests++;
        if ({col, row, pix_valid, locked, lock_lost, err_count, frame_sum, frame_done} !== 59'd0) begin
            fails++;
            $display("FAIL mid_reset: got col=%0d row=%0d pv=%b lk=%b ll=%b ec=%0d fs=%0d fd=%b want all 0",
                     col, row, pix_valid, locked, lock_lost, err_count, frame_sum, frame_done);
        end
        fd_cnt = 0;
        wait_lock(n);
        tests++;
        if (fd_cnt != 0) begin
            fails++;
            $display("FAIL early_done: got %0d pulses want 0", fd_cnt);
        end
        track = 1'b1;
        run_to(9, 5);
        tests++;
        if ({frame_done, frame_sum} !== {1'b1, 24'd60}) begin
            fails++;
            $display("FAIL relock_sum: got fd=%b sum=%0d want fd=1 sum=60", frame_done, frame_sum);
        end
        track = 1'b0;
    endtask

    task automatic test_no_vsync();
        reset_dut();
        vs_en = 1'b0;
        run_to(15, 4);
        for (int i = 0; i < 320; i++) begin
            tick();
            tests++;
            if ({locked, pix_valid} !== 2'b00 || col !== 12'(lc) || row !== 11'd0) begin
                fails++;
                $display("FAIL no_vsync: got lk=%b pv=%b col=%0d row=%0d want 0 0 %0d 0", locked, pix_valid, col, row, lc);
            end
        end
        vs_en = 1'b1;
    endtask

    task automatic test_saturate();
        int n;
        reset_dut();
        wait_lock(n);
        for (int i = 0; i < 256; i++) begin
            hmode = 2;
            run_to(11, 6);
            if (i >= 254) begin
                tests++;
                if ({lock_lost, locked, err_count} !== {1'b1, 1'b0, 8'd255}) begin
                    fails++;
                    $display("FAIL saturate %0d: got ll=%b lk=%b ec=%0d want ll=1 lk=0 ec=255", i, lock_lost, locked, err_count);
                end
            end
            run_to(15, 1);
            gr = 6;
            run_to(0, 6);
            run_to(0, 6);
            tests++;
            if (locked !== 1'b1) begin
                fails++;
                $display("FAIL fast_relock %0d: got %b want 1", i, locked);
            end
        end
        tests++;
        if (err_count !== 8'd255) begin
            fails++;
            $display("FAIL err_sat: got %0d want 255", err_count);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_hs_error();
        test_checksum();
        test_reset_mid();
        test_no_vsync();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
